w452_mem: RTL and testbench



---
 rtl/w452_mem_if.sv | 35 +++
 rtl/w452_mem.sv | 144 ++++++++++++++
 tb/tb_w452_mem.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/w452_mem_if.sv
// w452_mem_if: bundles the core-side read/store ports and the loader stream of w452_mem.
// Latency: reads combinational, stores and loader writes land on the accepting edge.
// Backpressure: ld_ready gates the loader byte stream; the core ports never stall.
`timescale 1ns/1ps
interface w452_mem_if;
   // core instruction fetch (halfword) and data read (word) ports
   logic [31:1] mem_rd0_addr;
   logic [15:0] mem_rd0_data;
   logic [31:1] mem_rd1_addr;
   logic [31:0] mem_rd1_data;
   // core store port
   logic [31:1] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_en;
   // byte-serial program loader and core reset control
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        ld_ready;
   logic        cpu_reset;
   logic        load_done;

   // master: core + host loader side
   modport master (
      output mem_rd0_addr, mem_rd1_addr, mem_wr_addr, mem_wr_data, mem_wr_en,
      output ld_data, ld_valid,
      input  mem_rd0_data, mem_rd1_data, ld_ready, cpu_reset, load_done
   );

   // slave: the memory responder
   modport slave (
      input  mem_rd0_addr, mem_rd1_addr, mem_wr_addr, mem_wr_data, mem_wr_en,
      input  ld_data, ld_valid,
      output mem_rd0_data, mem_rd1_data, ld_ready, cpu_reset, load_done
   );
endinterface

// File: rtl/w452_mem.sv
// w452_mem: halfword RAM serving w452 fetch/data reads and stores, plus a byte-serial image loader.
// Latency: reads combinational; stores/loader halfwords visible the cycle after the write edge.
// Backpressure: one loader byte per cycle while loading; ld_ready drops in RUN and during reset.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries rd0/rd1/wr core ports,
//        ld_data/ld_valid/ld_ready loader stream, cpu_reset and load_done status.
`timescale 1ns/1ps
module w452_mem #(
   parameter int ADDR_W = 12
) (
   input  logic     clk,
   input  logic     reset,
   w452_mem_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] idx_t;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_LEN2,
      S_LEN3,
      S_DATA_LO,
      S_DATA_HI,
      S_RUN
   } state_t;

   state_t      state_q;
   logic [31:0] cnt_q;      // halfwords still to load
   idx_t        ptr_q;      // next loader write index
   logic [7:0]  lo_q;       // pending low byte of the halfword being assembled
   logic        rdy_q;      // loader accepting bytes
   logic        run_q;      // image complete, core released

   logic [15:0] mem_q [DEPTH];

   logic        accept;
   logic [31:0] len_d;
   logic        ld_we;
   logic        st_we;
   idx_t        wr_idx;
   idx_t        wr_idx_p1;
   idx_t        rd0_idx;
   idx_t        rd1_idx;
   idx_t        rd1_idx_p1;

   // Address bits above the decoded range are ignored; addresses alias.
   logic unused_hi_addr;
   assign unused_hi_addr = ^{bus.mem_rd0_addr[31:ADDR_W+1],
                             bus.mem_rd1_addr[31:ADDR_W+1],
                             bus.mem_wr_addr[31:ADDR_W+1]};

   always_comb begin
      accept     = bus.ld_valid & bus.ld_ready;
      // full length as it stands once the LEN3 byte lands
      len_d      = {bus.ld_data, cnt_q[23:0]};
      ld_we      = accept && (state_q == S_DATA_HI);
      st_we      = bus.mem_wr_en && (state_q == S_RUN) && !reset;
      wr_idx     = bus.mem_wr_addr[ADDR_W:1];
      // idx_t arithmetic wraps the upper halfword back to index 0
      wr_idx_p1  = wr_idx + idx_t'(1);
      rd0_idx    = bus.mem_rd0_addr[ADDR_W:1];
      rd1_idx    = bus.mem_rd1_addr[ADDR_W:1];
      rd1_idx_p1 = rd1_idx + idx_t'(1);
   end

   // Loader FSM. rdy_q/run_q are the registered outputs; reset masks them below
   // so the core is held and the stream stalled in the same cycle reset is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LEN0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         lo_q    <= '0;
         rdy_q   <= 1'b1;
         run_q   <= 1'b0;
      end else if (accept) begin
         case (state_q)
            S_LEN0: begin
               cnt_q[7:0] <= bus.ld_data;
               state_q    <= S_LEN1;
            end
            S_LEN1: begin
               cnt_q[15:8] <= bus.ld_data;
               state_q     <= S_LEN2;
            end
            S_LEN2: begin
               cnt_q[23:16] <= bus.ld_data;
               state_q      <= S_LEN3;
            end
            S_LEN3: begin
               cnt_q <= len_d;
               if (len_d == 32'd0) begin
                  state_q <= S_RUN;
                  rdy_q   <= 1'b0;
                  run_q   <= 1'b1;
               end else begin
                  state_q <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               lo_q    <= bus.ld_data;
               state_q <= S_DATA_HI;
            end
            S_DATA_HI: begin
               ptr_q <= ptr_q + idx_t'(1);
               cnt_q <= cnt_q - 32'd1;
               if (cnt_q == 32'd1) begin
                  state_q <= S_RUN;
                  rdy_q   <= 1'b0;
                  run_q   <= 1'b1;
               end else begin
                  state_q <= S_DATA_LO;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   // Array is never cleared by reset. Loader and store writes are mutually
   // exclusive (loader only before RUN, store only in RUN).
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ptr_q] <= {bus.ld_data, lo_q};
      end
      if (st_we) begin
         mem_q[wr_idx]    <= bus.mem_wr_data[15:0];
         mem_q[wr_idx_p1] <= bus.mem_wr_data[31:16];
      end
   end

   // Reads are combinational from the array: no write-to-read bypass.
   assign bus.mem_rd0_data = mem_q[rd0_idx];
   assign bus.mem_rd1_data = {mem_q[rd1_idx_p1], mem_q[rd1_idx]};

   assign bus.ld_ready  = rdy_q & ~reset;
   assign bus.load_done = run_q & ~reset;
   assign bus.cpu_reset = ~(run_q & ~reset);

endmodule

// File: tb/tb_w452_mem.sv
// tb_w452_mem: directed bench for w452_mem - loader sequences plus a table of store/read vectors.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: loader bytes held valid until ld_ready, bounded by a cycle budget.
`timescale 1ns/1ps
module tb_w452_mem;
   localparam int ADDR_W = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   w452_mem_if bus();

   w452_mem #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        wr_en;
      logic [31:1] wr_addr;
      logic [31:0] wr_data;
      logic [31:1] rd0_addr;
      logic [31:1] rd1_addr;
      logic [15:0] exp_rd0;
      logic [31:0] exp_rd1;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset two cycles and checks the outputs it forces.
   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_ld_ready",  {31'd0, bus.ld_ready},  32'd0);
      chk("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
      chk("rst_load_done", {31'd0, bus.load_done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Offers one byte after 'gap' idle cycles; returns 1ns after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      got = 1'b0;
      repeat (gap) tick();
      bus.ld_valid = 1'b1;
      bus.ld_data  = b;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (bus.ld_ready) got = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.ld_valid = 1'b0;
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL ld_accept_timeout: byte %h never accepted, ld_ready stuck at 0", b);
      end
   endtask

   task automatic rd_chk(input string name, input logic [31:1] a0, input logic [31:1] a1,
                         input logic [15:0] e0, input logic [31:0] e1);
      bus.mem_rd0_addr = a0;
      bus.mem_rd1_addr = a1;
      @(negedge clk);
      chk({name, "_rd0"}, {16'd0, bus.mem_rd0_data}, {16'd0, e0});
      chk({name, "_rd1"}, bus.mem_rd1_data, e1);
      @(posedge clk);
      #1;
   endtask

   task automatic status_chk(input string name, input logic e_rdy, input logic e_cpu,
                             input logic e_done);
      @(negedge clk);
      chk({name, "_ld_ready"},  {31'd0, bus.ld_ready},  {31'd0, e_rdy});
      chk({name, "_cpu_reset"}, {31'd0, bus.cpu_reset}, {31'd0, e_cpu});
      chk({name, "_load_done"}, {31'd0, bus.load_done}, {31'd0, e_done});
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at 200us, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      // RUN-phase store/read table; mem[0]=1234, mem[1]=5678 on entry.
      vecs[0] = '{1'b0, 31'h0,         32'h0,        31'h0,    31'h0,         16'h1234, 32'h5678_1234};
      vecs[1] = '{1'b1, 31'h10,        32'h1111_2222, 31'h1,   31'h0,         16'h5678, 32'h5678_1234};
      vecs[2] = '{1'b1, 31'h10,        32'hDEAD_BEEF, 31'h10,  31'h10,        16'h2222, 32'h1111_2222};
      vecs[3] = '{1'b0, 31'h0,         32'h0,        31'h11,   31'h10,        16'hDEAD, 32'hDEAD_BEEF};
      vecs[4] = '{1'b1, 31'hFFF,       32'hAAAA_5555, 31'h10,  31'h0,         16'hBEEF, 32'h5678_1234};
      vecs[5] = '{1'b0, 31'h0,         32'h0,        31'hFFF,  31'hFFF,       16'h5555, 32'hAAAA_5555};
      vecs[6] = '{1'b0, 31'h0,         32'h0,        31'h0,    31'h0,         16'hAAAA, 32'h5678_AAAA};
      vecs[7] = '{1'b0, 31'h0,         32'h0,        31'h1011, 31'h4000_0010, 16'hDEAD, 32'hDEAD_BEEF};
      vecs[8] = '{1'b1, 31'h1000_0020, 32'h0BAD_F00D, 31'h11,  31'h10,        16'hDEAD, 32'hDEAD_BEEF};
      vecs[9] = '{1'b0, 31'h0,         32'h0,        31'h21,   31'h20,        16'h0BAD, 32'h0BAD_F00D};

      reset            = 1'b1;
      bus.mem_rd0_addr = '0;
      bus.mem_rd1_addr = '0;
      bus.mem_wr_addr  = '0;
      bus.mem_wr_data  = '0;
      bus.mem_wr_en    = 1'b0;
      bus.ld_data      = '0;
      bus.ld_valid     = 1'b0;

      // ---- reset, then N=2 back-to-back load ----
      do_reset();
      status_chk("post_rst", 1'b1, 1'b1, 1'b0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      rd_chk("ld_hw0_visible", 31'h0, 31'h0, 16'h1234, {dut.mem_q[1], 16'h1234});
      send_byte(8'h78, 0);
      status_chk("before_last", 1'b1, 1'b1, 1'b0);
      send_byte(8'h56, 0);
      status_chk("after_last", 1'b0, 1'b0, 1'b1);
      rd_chk("load_n2", 31'h0, 31'h0, 16'h1234, 32'h5678_1234);

      // bytes offered in RUN are not taken
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hFF;
      tick();
      tick();
      status_chk("run_extra", 1'b0, 1'b0, 1'b1);
      bus.ld_valid = 1'b0;

      // ---- table: stores, same-cycle old data, wrap, aliasing ----
      for (int i = 0; i < 10; i++) begin
         bus.mem_wr_en    = vecs[i].wr_en;
         bus.mem_wr_addr  = vecs[i].wr_addr;
         bus.mem_wr_data  = vecs[i].wr_data;
         bus.mem_rd0_addr = vecs[i].rd0_addr;
         bus.mem_rd1_addr = vecs[i].rd1_addr;
         @(negedge clk);
         chk($sformatf("vec%0d_rd0", i), {16'd0, bus.mem_rd0_data}, {16'd0, vecs[i].exp_rd0});
         chk($sformatf("vec%0d_rd1", i), bus.mem_rd1_data, vecs[i].exp_rd1);
         @(posedge clk);
         #1;
         bus.mem_wr_en = 1'b0;
      end

      // ---- reset during RUN, gapped load, store ignored while loading ----
      do_reset();
      bus.mem_wr_en   = 1'b1;
      bus.mem_wr_addr = 31'h10;
      bus.mem_wr_data = 32'hFFFF_FFFF;
      send_byte(8'h02, 1);
      send_byte(8'h00, 1);
      send_byte(8'h00, 1);
      send_byte(8'h00, 1);
      bus.mem_wr_en = 1'b0;
      send_byte(8'hCD, 1);
      send_byte(8'hAB, 1);
      send_byte(8'h21, 1);
      send_byte(8'h43, 1);
      status_chk("gap_done", 1'b0, 1'b0, 1'b1);
      rd_chk("gap_img", 31'h1, 31'h0, 16'h4321, 32'h4321_ABCD);
      rd_chk("wr_ignored", 31'h11, 31'h10, 16'hDEAD, 32'hDEAD_BEEF);

      // ---- reset mid-load, then N=1 reload ----
      do_reset();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      rd_chk("midload_hw0", 31'h1, 31'h0, 16'h4321, 32'h4321_2211);
      send_byte(8'h33, 0);
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      status_chk("reload_pend", 1'b1, 1'b1, 1'b0);
      send_byte(8'hBE, 0);
      status_chk("reload_done", 1'b0, 1'b0, 1'b1);
      rd_chk("reload_img", 31'h0, 31'h0, 16'hBEEF, 32'h4321_BEEF);

      // ---- N=0 header goes straight to RUN ----
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      status_chk("n0_len3", 1'b1, 1'b1, 1'b0);
      send_byte(8'h00, 0);
      status_chk("n0_run", 1'b0, 1'b0, 1'b1);
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hAA;
      tick();
      tick();
      status_chk("n0_extra", 1'b0, 1'b0, 1'b1);
      bus.ld_valid = 1'b0;
      rd_chk("n0_mem_kept", 31'h1, 31'h0, 16'h4321, 32'h4321_BEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
